// File: rtl/cpu_pkg.sv
// Values shared by the program counter and the return-address stack.
// Both blocks take their address width and PC increment from here.
package cpu_pkg;

    localparam int ADDR_W  = 10;
    localparam int PC_STEP = 2;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/lifo_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
// Not reset; validity is tracked by the owner's entry count.
module lifo_mem #(
    parameter int AW    = cpu_pkg::ADDR_W,
    parameter int DEPTH = 16
)(
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [AW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [AW-1:0]            rd_data
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack feeding the program counter's din/jmp inputs.
// Redirects are combinational so the PC loads on the same edge as CALL/RET.
module call_stack
    import cpu_pkg::*;
#(
    parameter int AW      = ADDR_W,
    parameter int DEPTH   = 16,
    parameter int PC_STEP = cpu_pkg::PC_STEP
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       call,
    input  logic                       ret,
    input  logic [AW-1:0]              pc_in,
    input  logic [AW-1:0]              target,
    input  logic                       clr_err,
    output logic [AW-1:0]              addr_out,
    output logic                       jmp_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       conflict
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] sp;
    logic [PW-1:0] rd_idx;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_data;
    logic [AW-1:0] ret_addr;
    logic          do_call;
    logic          do_ret;
    logic          do_both;

    assign do_call  = en & call & ~ret;
    assign do_ret   = en & ret & ~call;
    assign do_both  = en & call & ret;

    assign rd_idx   = sp - PW'(1);
    assign ret_addr = pc_in + AW'(PC_STEP);

    assign depth    = count;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign jmp_out  = do_call | do_ret;

    // Underflowing RET still requests a jump, but to address 0.
    always_comb begin
        addr_out = '0;
        if (do_call) begin
            addr_out = target;
        end else if (do_ret && !empty) begin
            addr_out = rd_data;
        end
    end

    lifo_mem #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_call),
        .wr_addr (sp),
        .wr_data (ret_addr),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // A full push keeps advancing sp, so the oldest entry is overwritten in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
        end else if (do_call) begin
            sp <= sp + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (do_ret && !empty) begin
            sp    <= sp - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Clear first so a same-cycle error event takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
                conflict  <= 1'b0;
            end
            if (do_call && full) begin
                overflow <= 1'b1;
            end
            if (do_ret && empty) begin
                underflow <= 1'b1;
            end
            if (do_both) begin
                conflict <= 1'b1;
            end
        end
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Return-address stack that sits directly upstream of the program counter and drives its din/jmp inputs.
- On CALL it pushes the return address (current PC + 2) and steers the call target to the PC.
- On RET it pops the saved address and steers that to the PC.
- It also reports depth, full/empty, and sticky error flags to the control/debug logic.

Parameters:
- AW, 10, address width; matches the program counter width.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- PC_STEP, 2, increment used to form the return address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  stage enable; same enable as the program counter.
- call  in  1  current instruction is CALL.
- ret  in  1  current instruction is RET.
- pc_in  in  AW  current PC value (program counter dout).
- target  in  AW  CALL destination address from decode.
- clr_err  in  1  synchronous clear of the sticky error flags.
- addr_out  out  AW  next-PC address; connects to program counter din.
- jmp_out  out  1  load request; connects to program counter jmp.
- depth  out  $clog2(DEPTH+1)  number of valid entries.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- overflow  out  1  sticky: a CALL occurred while full.
- underflow  out  1  sticky: a RET occurred while empty.
- conflict  out  1  sticky: call and ret were asserted together.

Behaviour:
- Storage and state: mem[DEPTH] of AW bits; write pointer sp ($clog2(DEPTH) bits); count ($clog2(DEPTH+1) bits).
- Reset (asynchronous, immediate): sp=0, count=0, overflow=underflow=conflict=0.
  - mem is not reset.
  - Outputs after reset: depth=0, empty=1, full=0, jmp_out=0, addr_out=0.
- addr_out and jmp_out are combinational, valid in the same cycle as call/ret, so the PC loads on the same rising edge (zero-latency redirect).
- State updates occur only on a rising edge with en=1. With en=0, jmp_out=0, addr_out=0, and no state changes.
- CALL (en & call & !ret):
  - addr_out = target; jmp_out = 1.
  - At the edge: mem[sp] <= (pc_in + PC_STEP) mod 2^AW; sp <= sp + 1 (wraps mod DEPTH).
  - If not full: count <= count + 1.
  - If full: count stays DEPTH, the oldest entry is silently overwritten (circular), and overflow <= 1.
- RET (en & ret & !call):
  - Not empty: addr_out = mem[sp-1] (index mod DEPTH); jmp_out = 1; at the edge sp <= sp - 1 and count <= count - 1.
  - Empty: addr_out = 0; jmp_out = 1; sp and count unchanged; underflow <= 1.
- call & ret with en=1:
  - jmp_out = 0, addr_out = 0.
  - No push or pop occurs; conflict <= 1.
- Neither call nor ret asserted: jmp_out = 0, addr_out = 0.
- clr_err (en-independent, synchronous): clears all three sticky flags at the next edge.
  - If an error event occurs in the same cycle, the set wins.
- After any mix of overflowing calls, a sequence of returns yields the DEPTH most recent return addresses in LIFO order, then underflows.
- rst mid-sequence: the stack is emptied immediately; a subsequent RET underflows and returns 0.

Decomposition:
- Shared package cpu_pkg holds:
  - localparam ADDR_W = 10 and PC_STEP = 2, used by both this block and the program counter.
  - typedef logic [ADDR_W-1:0] addr_t.
- One sub-module is natural: lifo_mem, a DEPTH x AW register array with one write port and one asynchronous read port, no reset.
- Pointer, count, flag logic and the output mux stay in call_stack.

Test Plan:
- Reset then RET with en=1 -> jmp_out=1, addr_out=0; underflow=1 next cycle; depth=0.
- pc_in=0x010, target=0x100, CALL -> same cycle addr_out=0x100, jmp_out=1; then depth=1. Next-cycle RET -> addr_out=0x012, then depth=0, empty=1.
- Nested CALLs at pc_in=0x020, 0x040, 0x060 -> RETs return 0x062, 0x042, 0x022 in order.
- 17 CALLs with pc_in=2*i (i=0..16):
  - depth saturates at 16, full=1, overflow=1.
  - 16 RETs return 0x022 down to 0x004; the 17th RET underflows with addr_out=0.
- pc_in=0x3FE, CALL -> return address wraps to 0x000 on the next RET.
- Conflict and stall cases:
  - call=ret=1 -> jmp_out=0, depth unchanged, conflict=1.
  - en=0 with call=1 -> no change.
  - clr_err -> all flags 0.
  - rst asserted mid-cycle clears depth immediately.
